// File: rtl/alu_issue_if.sv
// Handshake and ALU-side bundle for the alu_issue stage.
// The slave modport is the issue stage itself; the master modport is its environment.
interface alu_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [3:0]  req_cmd;

    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_cmd;
    logic        alu_oe;
    logic [15:0] alu_d;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_cmd;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_cmd,
        output req_ready,
        output alu_a, alu_b, alu_cmd, alu_oe,
        input  alu_d,
        output rsp_valid, rsp_data, rsp_cmd, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_cmd,
        input  req_ready,
        input  alu_a, alu_b, alu_cmd, alu_oe,
        output alu_d,
        input  rsp_valid, rsp_data, rsp_cmd, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_issue.sv
// Request FIFO plus SETUP/EVAL/RESP sequencer in front of the 8-bit ALU;
// registers the ALU result and returns it over a backpressured handshake.
module alu_issue #(
    parameter int DEPTH = 4
) (
    input logic       clock,
    input logic       resetn,
    alu_issue_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [3:0]  CMD_DIV    = 4'b0101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EVAL  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] cmd;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    entry_t        op_q;
    logic          alu_oe_q;
    logic          rsp_valid_q;
    logic [15:0]   rsp_data_q;
    logic [3:0]    rsp_cmd_q;
    logic          rsp_err_q;

    logic push, pop, capture;

    assign bus.req_ready = (count_q != FULL_COUNT);
    assign push          = bus.req_valid && bus.req_ready;

    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = EVAL;
            EVAL: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q] <= '{a: bus.req_a, b: bus.req_b, cmd: bus.req_cmd};
        end
    end

    // Enable and valid are registered off the next state so both are glitch-free.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            op_q        <= '0;
            alu_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cmd_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            alu_oe_q    <= (state_d == EVAL);
            rsp_valid_q <= (state_d == RESP);
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
                op_q   <= mem_q[rptr_q];
            end
            if (capture) begin
                rsp_data_q <= bus.alu_d;
                rsp_cmd_q  <= op_q.cmd;
                rsp_err_q  <= (op_q.cmd == CMD_DIV) && (op_q.b == 8'h00);
            end
        end
    end

    assign bus.alu_a     = op_q.a;
    assign bus.alu_b     = op_q.b;
    assign bus.alu_cmd   = op_q.cmd;
    assign bus.alu_oe    = alu_oe_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_cmd   = rsp_cmd_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
